// File: rtl/uart_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_bridge_pkg
// Brief    : Shared types and constants for the UART-to-memory command bridge.
// Revision : 1.0 - initial release
// ============================================================================
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h3F;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Big-endian byte pick: index 0 is the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_timer.sv
`default_nettype none
// ============================================================================
// Module   : frame_timer
// Brief    : Inter-byte watchdog; expires on the TIMEOUT-th enabled cycle
//            after the most recent restart.
// Revision : 1.0 - initial release
// ============================================================================
module frame_timer #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_restart,
    input  logic i_enable,
    output logic o_expired
);

    localparam int             CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  C_LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_restart) begin
            r_count <= C_LOAD;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = i_enable && !i_restart && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_bridge
// Brief    : Assembles read/write frames from UART bytes, runs one bus cycle
//            per frame and answers with an acknowledge byte or the read word.
// Revision : 1.0 - initial release
// ============================================================================
module uart_mem_bridge
    import uart_bridge_pkg::*;
#(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_done,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    output logic        we_o,
    output logic        rd_o,
    input  logic        ack_i,
    output logic        busy,
    output logic [7:0]  err_cnt,
    output logic [7:0]  drop_cnt
);

    state_t      r_state, w_state;
    logic [1:0]  r_idx, w_idx;
    logic        r_is_write, w_is_write;
    logic [1:0]  r_last, w_last;
    logic [31:0] r_addr, w_addr;
    logic [31:0] r_wdata, w_wdata;
    logic [31:0] r_rdata, w_rdata;
    logic [7:0]  w_tx_data;
    logic        w_tx_send;
    logic [31:0] w_addr_o, w_data_o;
    logic        w_we, w_rd, w_busy;
    logic [7:0]  w_err_cnt, w_drop_cnt;
    logic        w_in_frame, w_timer_restart, w_timer_expired;
    logic [31:0] w_addr_shift, w_data_shift;

    assign w_in_frame      = (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign w_timer_restart = rx_valid || !w_in_frame;
    assign w_addr_shift    = {r_addr[23:0], rx_data};
    assign w_data_shift    = {r_wdata[23:0], rx_data};

    frame_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_frame_timer (
        .clk       (clk),
        .rstn      (rstn),
        .i_restart (w_timer_restart),
        .i_enable  (w_in_frame),
        .o_expired (w_timer_expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_is_write <= 1'b0;
            r_last     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            tx_data    <= '0;
            tx_send    <= 1'b0;
            addr_o     <= '0;
            data_o     <= '0;
            we_o       <= 1'b0;
            rd_o       <= 1'b0;
            busy       <= 1'b0;
            err_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            r_state    <= w_state;
            r_idx      <= w_idx;
            r_is_write <= w_is_write;
            r_last     <= w_last;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_rdata    <= w_rdata;
            tx_data    <= w_tx_data;
            tx_send    <= w_tx_send;
            addr_o     <= w_addr_o;
            data_o     <= w_data_o;
            we_o       <= w_we;
            rd_o       <= w_rd;
            busy       <= w_busy;
            err_cnt    <= w_err_cnt;
            drop_cnt   <= w_drop_cnt;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_is_write = r_is_write;
        w_last     = r_last;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_rdata    = r_rdata;
        w_tx_data  = tx_data;
        w_tx_send  = 1'b0;
        w_addr_o   = addr_o;
        w_data_o   = data_o;
        w_err_cnt  = err_cnt;
        w_drop_cnt = drop_cnt;

        case (r_state)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_WRITE) begin
                        w_is_write = 1'b1;
                        w_state    = ST_ADDR;
                    end else if (rx_data == CMD_READ) begin
                        w_is_write = 1'b0;
                        w_state    = ST_ADDR;
                    end else begin
                        w_state   = ST_RESP;
                        w_last    = 2'd0;
                        w_tx_data = RSP_ERR;
                        w_tx_send = 1'b1;
                        w_err_cnt = sat_inc(err_cnt);
                    end
                end
            end
            ST_ADDR: begin
                if (rx_valid) begin
                    w_addr = w_addr_shift;
                    w_idx  = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_addr_o = {w_addr_shift[31:2], 2'b00};
                        w_state  = r_is_write ? ST_DATA : ST_BUS;
                    end
                end else if (w_timer_expired) begin
                    w_state   = ST_IDLE;
                    w_err_cnt = sat_inc(err_cnt);
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    w_wdata = w_data_shift;
                    w_idx   = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_data_o = w_data_shift;
                        w_state  = ST_BUS;
                    end
                end else if (w_timer_expired) begin
                    w_state   = ST_IDLE;
                    w_err_cnt = sat_inc(err_cnt);
                end
            end
            ST_BUS: begin
                if (ack_i) begin
                    w_state   = ST_RESP;
                    w_tx_send = 1'b1;
                    if (r_is_write) begin
                        w_tx_data = RSP_OK;
                        w_last    = 2'd0;
                    end else begin
                        w_rdata   = data_i;
                        w_tx_data = data_i[31:24];
                        w_last    = 2'd3;
                    end
                end
            end
            ST_RESP: begin
                if (tx_done) begin
                    if (r_idx == r_last) begin
                        w_state = ST_IDLE;
                    end else begin
                        w_idx     = r_idx + 2'd1;
                        w_tx_data = word_byte(r_rdata, w_idx);
                        w_tx_send = 1'b1;
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        // Bytes arriving while a transaction is in progress are counted and discarded.
        if (rx_valid && ((r_state == ST_BUS) || (r_state == ST_RESP))) begin
            w_drop_cnt = sat_inc(drop_cnt);
        end

        if (w_state != r_state) begin
            w_idx = '0;
        end

        w_we   = (w_state == ST_BUS) && w_is_write;
        w_rd   = (w_state == ST_BUS) && !w_is_write;
        w_busy = (w_state != ST_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mem_bridge
// Brief    : Scoreboard bench with a memory/UART device model around the bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mem_bridge;

    localparam int TIMEOUT = 40;

    localparam int S_TX_DATA  = 0;
    localparam int S_TX_SEND  = 1;
    localparam int S_ADDR     = 2;
    localparam int S_DATA     = 3;
    localparam int S_WE       = 4;
    localparam int S_RD       = 5;
    localparam int S_BUSY     = 6;
    localparam int S_ERR      = 7;
    localparam int S_DROP     = 8;
    localparam int S_TXQ      = 9;
    localparam int S_BUSQ     = 10;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        int          len;
    } bus_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_done;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [31:0] data_i;
    logic        we_o;
    logic        rd_o;
    logic        ack_i;
    logic        busy;
    logic [7:0]  err_cnt;
    logic [7:0]  drop_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_tx[$];
    bus_t        exp_bus[$];
    chk_t        chk_q[$];
    logic [31:0] ref_mem[logic [29:0]];
    logic [31:0] dev_mem[logic [29:0]];
    int          ack_delay = 0;
    logic        chk_strobe = 1'b0;
    int          exp_err = 0;
    int          exp_drop = 0;

    always #5 clk = ~clk;

    uart_mem_bridge #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_done  (tx_done),
        .addr_o   (addr_o),
        .data_o   (data_o),
        .data_i   (data_i),
        .we_o     (we_o),
        .rd_o     (rd_o),
        .ack_i    (ack_i),
        .busy     (busy),
        .err_cnt  (err_cnt),
        .drop_cnt (drop_cnt)
    );

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] get_sig(input int sel);
        case (sel)
            S_TX_DATA: return {24'd0, tx_data};
            S_TX_SEND: return {31'd0, tx_send};
            S_ADDR:    return addr_o;
            S_DATA:    return data_o;
            S_WE:      return {31'd0, we_o};
            S_RD:      return {31'd0, rd_o};
            S_BUSY:    return {31'd0, busy};
            S_ERR:     return {24'd0, err_cnt};
            S_DROP:    return {24'd0, drop_cnt};
            S_TXQ:     return exp_tx.size();
            default:   return exp_bus.size();
        endcase
    endfunction

    // Memory device: acknowledges each request after ack_delay cycles.
    initial begin : bus_device
        logic [31:0] ra;
        logic [31:0] rw;
        logic        rwe;
        int          dly;
        ack_i  = 1'b0;
        data_i = '0;
        forever begin
            @(negedge clk);
            if (we_o || rd_o) begin
                ra  = addr_o;
                rw  = data_o;
                rwe = we_o;
                dly = ack_delay;
                repeat (dly) @(negedge clk);
                if (rwe && we_o) dev_mem[ra[31:2]] = rw;
                if (rwe) data_i = $urandom;
                else     data_i = dev_mem.exists(ra[31:2]) ? dev_mem[ra[31:2]] : dflt(ra);
                ack_i = 1'b1;
                @(negedge clk);
                ack_i  = 1'b0;
                data_i = $urandom;
            end
        end
    end

    // UART transmitter: reports completion a few cycles after each send.
    initial begin : uart_tx_device
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (tx_send) begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
                tx_done = 1'b1;
            end
        end
    end

    initial begin : monitor
        logic        prev_req;
        logic        req;
        int          cyc;
        bus_t        cur;
        logic [31:0] held_addr;
        logic [31:0] held_data;
        logic        held_we;
        logic        tx_hold;
        logic [7:0]  tx_held;
        logic [7:0]  e;
        chk_t        c;
        logic [31:0] act;
        prev_req  = 1'b0;
        cyc       = 0;
        cur.len   = 0;
        held_addr = '0;
        held_data = '0;
        held_we   = 1'b0;
        tx_hold   = 1'b0;
        tx_held   = '0;
        forever begin
            @(negedge clk or posedge chk_strobe);
            if (!clk) begin
                if (tx_hold) begin
                    n_vec++;
                    if (tx_data !== tx_held) begin
                        n_err++;
                        $display("FAIL tx_stable: got %02h expected %02h", tx_data, tx_held);
                    end
                end
                if (tx_done) tx_hold = 1'b0;
                if (tx_send) begin
                    n_vec++;
                    if (exp_tx.size() == 0) begin
                        n_err++;
                        $display("FAIL tx_unexpected: got %02h expected no byte", tx_data);
                    end else begin
                        e = exp_tx.pop_front();
                        if (tx_data !== e) begin
                            n_err++;
                            $display("FAIL tx_byte: got %02h expected %02h", tx_data, e);
                        end
                    end
                    tx_hold = 1'b1;
                    tx_held = tx_data;
                end

                req = we_o | rd_o;
                if (req && !prev_req) begin
                    n_vec++;
                    if (exp_bus.size() == 0) begin
                        n_err++;
                        cur.len = 0;
                        $display("FAIL bus_unexpected: got we=%0b rd=%0b addr=%08h expected no request",
                                 we_o, rd_o, addr_o);
                    end else begin
                        cur = exp_bus.pop_front();
                        if (we_o !== cur.we || rd_o !== !cur.we ||
                            addr_o !== {cur.addr[31:2], 2'b00} ||
                            (cur.we && data_o !== cur.data)) begin
                            n_err++;
                            $display("FAIL bus_req: got we=%0b rd=%0b addr=%08h data=%08h expected we=%0b addr=%08h data=%08h",
                                     we_o, rd_o, addr_o, data_o, cur.we, {cur.addr[31:2], 2'b00}, cur.data);
                        end
                    end
                    held_addr = addr_o;
                    held_data = data_o;
                    held_we   = we_o;
                    cyc       = 1;
                end else if (req) begin
                    cyc++;
                    n_vec++;
                    if (addr_o !== held_addr || data_o !== held_data || we_o !== held_we || (we_o && rd_o)) begin
                        n_err++;
                        $display("FAIL bus_stable: got addr=%08h data=%08h we=%0b rd=%0b expected addr=%08h data=%08h we=%0b",
                                 addr_o, data_o, we_o, rd_o, held_addr, held_data, held_we);
                    end
                end else if (prev_req && cur.len != 0) begin
                    n_vec++;
                    if (cyc != cur.len) begin
                        n_err++;
                        $display("FAIL bus_len: got %0d cycles expected %0d", cyc, cur.len);
                    end
                end
                prev_req = req;
            end

            while (chk_q.size() > 0) begin
                c   = chk_q.pop_front();
                act = get_sig(c.sel);
                n_vec++;
                if (act !== c.exp) begin
                    n_err++;
                    $display("FAIL %s: got %0h expected %0h", c.name, act, c.exp);
                end
            end
        end
    end

    task automatic push_chk(input string n, input int s, input logic [31:0] e);
        chk_t c;
        c.name = n;
        c.sel  = s;
        c.exp  = e;
        chk_q.push_back(c);
    endtask

    function automatic int rgap();
        return int'($urandom_range(0, 2));
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string n);
        int i;
        i = 0;
        while (busy && i < 5000) begin
            @(negedge clk);
            i++;
        end
        push_chk(n, S_BUSY, 32'd0);
    endtask

    task automatic post_checks();
        push_chk("err_cnt", S_ERR, exp_err);
        push_chk("drop_cnt", S_DROP, exp_drop);
        push_chk("tx_queue_left", S_TXQ, 32'd0);
        push_chk("bus_queue_left", S_BUSQ, 32'd0);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int dly,
                            input int inject, input int long_gap_pos);
        bus_t b;
        ack_delay = dly;
        b.we   = 1'b1;
        b.addr = a;
        b.data = d;
        b.len  = dly + 1;
        exp_bus.push_back(b);
        exp_tx.push_back(8'h4B);
        ref_mem[a[31:2]] = d;
        send_byte(8'h57, rgap());
        for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8], (i == long_gap_pos) ? TIMEOUT - 1 : rgap());
        for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8], rgap());
        for (int i = 0; i < inject; i++) begin
            send_byte(8'($urandom), 2);
            exp_drop = sat(exp_drop + 1);
        end
        wait_idle("write_idle");
        post_checks();
    endtask

    task automatic do_read(input logic [31:0] a, input int dly);
        bus_t        b;
        logic [31:0] w;
        ack_delay = dly;
        w = ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : dflt(a);
        b.we   = 1'b0;
        b.addr = a;
        b.data = '0;
        b.len  = dly + 1;
        exp_bus.push_back(b);
        for (int i = 0; i < 4; i++) exp_tx.push_back(w[31-8*i -: 8]);
        send_byte(8'h52, rgap());
        for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8], rgap());
        wait_idle("read_idle");
        post_checks();
    endtask

    task automatic do_bad(input logic [7:0] c);
        exp_tx.push_back(8'h3F);
        exp_err = sat(exp_err + 1);
        send_byte(c, rgap());
        wait_idle("bad_idle");
        post_checks();
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] pool [4];
        bus_t        b;
        logic [31:0] a;
        logic [7:0]  c;
        int          k;

        pool[0] = 32'h0000_0104;
        pool[1] = 32'h0000_2000;
        pool[2] = 32'hFFFF_FFFC;
        pool[3] = 32'h8000_0010;

        rstn     = 1'b1;
        rx_data  = '0;
        rx_valid = 1'b0;
        #1 rstn  = 1'b0;
        @(negedge clk);
        push_chk("rst_tx_data", S_TX_DATA, 32'd0);
        push_chk("rst_tx_send", S_TX_SEND, 32'd0);
        push_chk("rst_addr_o", S_ADDR, 32'd0);
        push_chk("rst_data_o", S_DATA, 32'd0);
        push_chk("rst_we_o", S_WE, 32'd0);
        push_chk("rst_rd_o", S_RD, 32'd0);
        push_chk("rst_busy", S_BUSY, 32'd0);
        push_chk("rst_err_cnt", S_ERR, 32'd0);
        push_chk("rst_drop_cnt", S_DROP, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Directed frames from the plan.
        ref_mem[30'h41] = 32'hCAFE_F00D;
        dev_mem[30'h41] = 32'hCAFE_F00D;
        do_read(32'h0000_0104, 2);
        do_write(32'h0000_0107, 32'hDEAD_BEEF, 0, 0, -1);
        do_read(32'h0000_0104, 0);
        do_bad(8'h41);

        // Partial frame abandoned by the inter-byte timeout.
        send_byte(8'h57, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        repeat (TIMEOUT + 5) @(negedge clk);
        exp_err = sat(exp_err + 1);
        push_chk("timeout_idle", S_BUSY, 32'd0);
        post_checks();
        do_write(32'h0000_2000, 32'h0BAD_F00D, 1, 0, -1);

        // Largest legal inter-byte gap still completes the frame.
        do_write(32'h0000_2000, 32'h1357_9BDF, 1, 0, 2);

        // Bytes arriving during a stalled bus cycle are dropped.
        do_write(32'h8000_0010, 32'h0246_8ACE, 50, 3, -1);
        do_read(32'h8000_0010, 3);

        // Reset while the write request is outstanding.
        ack_delay = 30;
        b.we   = 1'b1;
        b.addr = 32'h0000_0200;
        b.data = 32'h1234_5678;
        b.len  = 0;
        exp_bus.push_back(b);
        send_byte(8'h57, 0);
        for (int i = 0; i < 4; i++) send_byte(b.addr[31-8*i -: 8], 0);
        for (int i = 0; i < 4; i++) send_byte(b.data[31-8*i -: 8], 0);
        repeat (3) @(negedge clk);
        push_chk("we_before_rst", S_WE, 32'd1);
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        push_chk("we_async_rst", S_WE, 32'd0);
        push_chk("busy_async_rst", S_BUSY, 32'd0);
        chk_strobe = 1'b1;
        #1 chk_strobe = 1'b0;
        exp_err  = 0;
        exp_drop = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        push_chk("late_ack_busy", S_BUSY, 32'd0);
        post_checks();
        do_write(32'h0000_0204, 32'hA5A5_5A5A, 2, 0, -1);
        do_read(32'h0000_0204, 1);

        // Randomised mix of frames against the reference memory.
        for (int n = 0; n < 24; n++) begin
            k = int'($urandom_range(0, 9));
            a = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
            if (k < 4) begin
                do_write(a, $urandom, int'($urandom_range(0, 4)), 0, -1);
            end else if (k < 8) begin
                do_read(a, int'($urandom_range(0, 4)));
            end else begin
                c = 8'($urandom);
                while (c == 8'h57 || c == 8'h52) c = 8'($urandom);
                do_bad(c);
            end
        end

        repeat (10) @(negedge clk);
        post_checks();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_mem_bridge.md
# uart_mem_bridge

Byte-serial command bridge between the `uart` byte interface and the `ddr3_dev` word bus. It assembles read and write frames from received UART bytes and issues one bus transaction per frame. It then returns an acknowledge byte or the read word over UART. In the SoC it replaces the free-running DDR3 test sequencer, so a host PC can load and inspect memory.

## Interface
- `TIMEOUT`, default 1_000_000: idle clk cycles allowed between bytes of one frame before the frame is discarded. Must be ≥ 2.
- `clk`  in  1  system clock (clk_sys domain).
- `rstn`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  received byte (uart `data_out`).
- `rx_valid`  in  1  one-cycle pulse: `rx_data` valid (uart `data_received`).
- `tx_data`  out  8  byte to transmit (uart `data_in`).
- `tx_send`  out  1  one-cycle pulse that starts transmission (uart `data_send`).
- `tx_done`  in  1  one-cycle pulse: previous byte fully sent (uart `data_sent`).
- `addr_o`  out  32  bus word address; bits [1:0] always 0.
- `data_o`  out  32  bus write data.
- `data_i`  in  32  bus read data, valid when `ack_i` is high.
- `we_o`  out  1  write request, level.
- `rd_o`  out  1  read request, level.
- `ack_i`  in  1  one-cycle completion pulse from `ddr3_dev`.
- `busy`  out  1  high in any state other than IDLE.
- `err_cnt`  out  8  saturating count of bad command bytes plus frame timeouts.
- `drop_cnt`  out  8  saturating count of bytes received while not accepting.

## Operation
- Frame formats (multi-byte fields are big-endian):
  - Write: 0x57, A3..A0, D3..D0. Response 0x4B.
  - Read: 0x52, A3..A0. Response D3..D0.
- Bad command: any other first byte → respond 0x3F, increment `err_cnt`.
- The address is stored as received. `addr_o` drives {A[31:2], 2'b00}.
- FSM states:
  - IDLE: on `rx_valid`, 0x57 → ADDR (write), 0x52 → ADDR (read), other → RESP with byte 0x3F.
  - ADDR: shift in 4 bytes. After the 4th, a write goes to DATA and a read goes to BUS.
  - DATA: shift in 4 bytes, then go to BUS.
  - BUS: hold `we_o` or `rd_o` high, with `addr_o`/`data_o` stable, until `ack_i`. For a read, capture `data_i` on `ack_i`. Then go to RESP.
  - RESP: pulse `tx_send` with the current byte, wait for `tx_done`, advance the byte index. A write sends 1 byte, a read 4, an error 1. Then return to IDLE.
- Byte index: 2-bit counter, cleared on every state entry.
- Frame timeout: in ADDR or DATA, a counter runs and resets on each `rx_valid`. On reaching `TIMEOUT`:
  - return to IDLE, increment `err_cnt`;
  - no bus cycle and no response.
- `rx_valid` in BUS or RESP: byte discarded, `drop_cnt` incremented, FSM unaffected.
- `ack_i` outside BUS: ignored.
- `tx_done` outside RESP: ignored.
- Counters saturate at 255.
- Reset mid-operation:
  - FSM returns to IDLE immediately and the bus request drops asynchronously.
  - A `ddr3_dev` transaction in flight is abandoned; its late `ack_i` is ignored.

## Timing
- Reset values:
  - `tx_data`=0, `tx_send`=0, `addr_o`=0, `data_o`=0, `we_o`=0, `rd_o`=0, `busy`=0, `err_cnt`=0, `drop_cnt`=0.
  - FSM in IDLE, all counters 0.
- All outputs registered.
- Request assertion: `we_o`/`rd_o` rise 1 cycle after the `rx_valid` of the last frame byte.
- Request release: `we_o`/`rd_o` fall on the cycle after `ack_i`. An `ack_i` on the first request cycle is legal.
- First `tx_send` occurs 1 cycle after `ack_i`. For an error response it occurs 1 cycle after the bad byte.
- Next `tx_send`: 1 cycle after `tx_done`.
- `tx_data` is stable from `tx_send` until the following `tx_done`.
- Return to IDLE: `busy` falls 1 cycle after the final `tx_done`.
- A byte arriving on that same cycle is accepted as a new command.
- Timeout fires when the counter equals `TIMEOUT`, i.e. on the `TIMEOUT`-th cycle after the last byte.

## Structure
- Package `uart_bridge_pkg`: FSM state enum; constants CMD_WRITE=0x57, CMD_READ=0x52, RSP_OK=0x4B, RSP_ERR=0x3F.
- One sub-module, `frame_timer`: loadable down-counter with `restart`, `enable` and `expired`, parameterised by `TIMEOUT`.
- Everything else stays in `uart_mem_bridge`.

## Test plan
- Write frame 57 00 00 01 07 DE AD BE EF:
  - exactly one `we_o` cycle with `addr_o`=0x00000104, `data_o`=0xDEADBEEF;
  - response 0x4B.
- Read frame 52 00 00 01 04, bus returns 0xCAFEF00D:
  - `rd_o` with `addr_o`=0x00000104;
  - tx bytes CA FE F0 0D in order, `busy` low afterwards.
- Byte 0x41 in IDLE → tx 0x3F, `err_cnt`=1, no bus request.
- Send 57 00 00 then stall `TIMEOUT`+5 cycles:
  - FSM back in IDLE, `err_cnt` incremented, no response;
  - a following full write frame completes normally.
- Stall `ack_i` 50 cycles and inject 3 bytes during BUS:
  - `drop_cnt`=3, request held stable throughout, frame completes.
- Assert `rstn`=0 while `we_o` is high → `we_o`=0 immediately.
  - After release, a late `ack_i` causes no tx, and the next frame executes normally.
